// File: rtl/receive_pkg.sv
// Shared types for the inbound score/feature receiver.
// The SRAM address width is shared with the other SRAM masters.
package receive_pkg;

    localparam int SRAM_ADDR_W = 21;

    typedef logic signed [15:0] num;

endpackage

// File: rtl/receive.sv
// Assembles 16-bit values from UART bytes (low byte first) and writes them to
// consecutive SRAM words; the SRAM bus is released (Z) while idle.
module receive
    import receive_pkg::*;
#(
    parameter int                     n_values  = 10,
    parameter logic [SRAM_ADDR_W-1:0] base_addr = 21'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_recv,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output num                     data_out,
    output logic [SRAM_ADDR_W-1:0] data_addr,
    output logic                   write_data,
    input  logic                   sram_ready,
    input  logic                   sram_idle,
    output logic                   recv_done,
    output logic                   overrun,
    output logic [2:0]             receiver_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_LO   = 3'd1,
        ST_RX_HI   = 3'd2,
        ST_WAITING = 3'd3,
        ST_WRITING = 3'd4
    } receive_state_t;

    localparam logic [7:0] LAST_INDEX = 8'(n_values - 1);

    receive_state_t         state_q, state_d;
    logic [7:0]             index_q, index_d;
    logic [7:0]             lo_q, lo_d;
    logic [7:0]             hi_q, hi_d;
    logic                   recv_done_q, recv_done_d;
    logic                   overrun_q, overrun_d;

    logic [SRAM_ADDR_W-1:0] wr_addr_s;
    logic [SRAM_ADDR_W-1:0] addr_drv_s;
    logic [15:0]            data_drv_s;
    logic                   write_drv_s;
    logic                   bus_en_s;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            index_q     <= 8'd0;
            lo_q        <= 8'd0;
            hi_q        <= 8'd0;
            recv_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            recv_done_q <= recv_done_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic; bytes arriving while a write is pending are dropped.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        recv_done_d = 1'b0;
        overrun_d   = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (start_recv) begin
                    index_d   = 8'd0;
                    overrun_d = 1'b0;
                    state_d   = ST_RX_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RX_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_data;
                    state_d = ST_RX_HI;
                end else begin
                    state_d = ST_RX_LO;
                end
            end
            ST_RX_HI: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = sram_idle ? ST_WRITING : ST_WAITING;
                end else begin
                    state_d = ST_RX_HI;
                end
            end
            ST_WAITING: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (sram_idle) begin
                    state_d = ST_WRITING;
                end else begin
                    state_d = ST_WAITING;
                end
            end
            ST_WRITING: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (sram_ready) begin
                    // index wraps naturally at 256 values
                    index_d = index_q + 8'd1;
                    if (index_q == LAST_INDEX) begin
                        state_d     = ST_IDLE;
                        recv_done_d = 1'b1;
                    end else begin
                        state_d = ST_RX_LO;
                    end
                end else begin
                    state_d = ST_WRITING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wr_addr_s = base_addr + (SRAM_ADDR_W'(index_q) << 1);

    // Bus values: driven during a write, driven low while busy otherwise.
    always_comb begin
        addr_drv_s  = '0;
        data_drv_s  = 16'd0;
        write_drv_s = 1'b0;
        bus_en_s    = (state_q != ST_IDLE);
        if (state_q == ST_WRITING) begin
            addr_drv_s  = wr_addr_s;
            data_drv_s  = {hi_q, lo_q};
            write_drv_s = 1'b1;
        end else begin
            write_drv_s = 1'b0;
        end
    end

    assign data_addr  = bus_en_s ? addr_drv_s  : {SRAM_ADDR_W{1'bz}};
    assign data_out   = bus_en_s ? data_drv_s  : {16{1'bz}};
    assign write_data = bus_en_s ? write_drv_s : 1'bz;

    assign recv_done      = recv_done_q;
    assign overrun        = overrun_q;
    assign receiver_state = state_q;

endmodule

// File: tb/tb_receive.sv
// Directed bench for receive: a 3-value instance exercises protocol corners,
// a 256-value instance exercises the full index range.
module tb_receive;
    import receive_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       sram_idle = 1'b1;
    logic       use_b = 1'b0;

    logic start_a, start_b, rxv_a, rxv_b;
    assign start_a = start & !use_b;
    assign start_b = start & use_b;
    assign rxv_a   = rx_valid & !use_b;
    assign rxv_b   = rx_valid & use_b;

    wire [15:0] dout_a, dout_b;
    wire [20:0] addr_a, addr_b;
    wire        wr_a, wr_b;
    logic       ready_a = 1'b0, ready_b = 1'b0;
    logic       done_a, done_b, ovr_a, ovr_b;
    logic [2:0] st_a, st_b;

    int errors = 0;
    int checks = 0;
    int done_cnt_a = 0, done_cnt_b = 0;
    int cnt_a = 0, cnt_b = 0;
    logic [20:0] wq_addr_a[$], wq_addr_b[$];
    logic [15:0] wq_data_a[$], wq_data_b[$];

    receive #(.n_values(3), .base_addr(21'h100)) dut_a (
        .clk(clk), .reset(reset), .start_recv(start_a), .rx_data(rx_data),
        .rx_valid(rxv_a), .data_out(dout_a), .data_addr(addr_a),
        .write_data(wr_a), .sram_ready(ready_a), .sram_idle(sram_idle),
        .recv_done(done_a), .overrun(ovr_a), .receiver_state(st_a)
    );

    receive #(.n_values(256), .base_addr(21'h100)) dut_b (
        .clk(clk), .reset(reset), .start_recv(start_b), .rx_data(rx_data),
        .rx_valid(rxv_b), .data_out(dout_b), .data_addr(addr_b),
        .write_data(wr_b), .sram_ready(ready_b), .sram_idle(sram_idle),
        .recv_done(done_b), .overrun(ovr_b), .receiver_state(st_b)
    );

    always #5 clk = ~clk;

    // SRAM model: accepts a write on the second cycle write_data is seen high.
    always @(negedge clk) begin
        if (wr_a === 1'b1) begin
            cnt_a   <= cnt_a + 1;
            ready_a <= (cnt_a == 1);
            if (cnt_a == 1) begin
                wq_addr_a.push_back(addr_a);
                wq_data_a.push_back(dout_a);
            end
        end else begin
            cnt_a   <= 0;
            ready_a <= 1'b0;
        end
        if (wr_b === 1'b1) begin
            cnt_b   <= cnt_b + 1;
            ready_b <= (cnt_b == 1);
            if (cnt_b == 1) begin
                wq_addr_b.push_back(addr_b);
                wq_data_b.push_back(dout_b);
            end
        end else begin
            cnt_b   <= 0;
            ready_b <= 1'b0;
        end
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
        if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A released bus reads Z on a 4-state simulator and 0 on a 2-state one.
    function automatic logic released_a();
        return (wr_a === 1'bz || wr_a === 1'b0) &&
               (addr_a === {21{1'bz}} || addr_a === 21'd0) &&
               (dout_a === {16{1'bz}} || dout_a === 16'd0);
    endfunction

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        logic [2:0] cur;
        for (int i = 0; i < budget; i++) begin
            cur = use_b ? st_b : st_a;
            if (cur == s) return;
            @(negedge clk);
        end
        cur = use_b ? st_b : st_a;
        check_eq("wait_state_timeout", 32'(cur), 32'(s));
    endtask

    task automatic send_value(input logic [15:0] v);
        wait_state(3'd1, 40);
        send(v[7:0]);
        send(v[15:8]);
    endtask

    logic [15:0] exp_d [3];

    initial begin
        repeat (2) @(negedge clk);
        check_eq("reset_state", 32'(st_a), 32'd0);
        check_eq("reset_done", 32'(done_a), 32'd0);
        check_eq("reset_overrun", 32'(ovr_a), 32'd0);
        check_eq("reset_bus_released", 32'(released_a()), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Bytes arriving in IDLE are ignored without flagging overrun.
        send(8'h55);
        send(8'h66);
        check_eq("idle_rx_state", 32'(st_a), 32'd0);
        check_eq("idle_rx_overrun", 32'(ovr_a), 32'd0);
        check_eq("idle_bus_released", 32'(released_a()), 32'd1);

        // Normal transfer with a start during RX_HI and a stalled SRAM bus.
        pulse_start();
        check_eq("start_to_rx_lo", 32'(st_a), 32'd1);
        send(8'h34);
        check_eq("after_lo_state", 32'(st_a), 32'd2);
        pulse_start();
        check_eq("start_in_rx_hi_ignored", 32'(st_a), 32'd2);
        send(8'h12);
        wait_state(3'd1, 40);
        send(8'hCD);
        sram_idle = 1'b0;
        send(8'hAB);
        for (int i = 0; i < 5; i++) begin
            check_eq("waiting_state", 32'(st_a), 32'd3);
            check_eq("waiting_write_low", 32'(wr_a === 1'b0), 32'd1);
            check_eq("waiting_addr_zero", 32'(addr_a === 21'd0), 32'd1);
            @(negedge clk);
        end
        sram_idle = 1'b1;
        wait_state(3'd1, 40);
        send(8'h01);
        send(8'h80);
        check_eq("last_byte_write_latency", 32'(wr_a === 1'b1), 32'd1);
        wait_state(3'd0, 40);
        @(negedge clk);
        check_eq("done_pulse_count", 32'(done_cnt_a), 32'd1);
        check_eq("done_pulse_ended", 32'(done_a), 32'd0);
        check_eq("xfer1_overrun", 32'(ovr_a), 32'd0);
        check_eq("xfer1_write_count", 32'(wq_addr_a.size()), 32'd3);
        exp_d[0] = 16'h1234; exp_d[1] = 16'hABCD; exp_d[2] = 16'h8001;
        for (int i = 0; i < 3 && i < wq_addr_a.size(); i++) begin
            check_eq("xfer1_addr", 32'(wq_addr_a[i]), 32'h100 + 32'(2 * i));
            check_eq("xfer1_data", 32'(wq_data_a[i]), 32'(exp_d[i]));
        end

        // Byte arriving during WRITING is dropped and flagged.
        wq_addr_a.delete();
        wq_data_a.delete();
        pulse_start();
        send_value(16'h2211);
        send(8'hEE);
        check_eq("overrun_set", 32'(ovr_a), 32'd1);
        send_value(16'h4433);
        send_value(16'h6655);
        wait_state(3'd0, 40);
        @(negedge clk);
        check_eq("ovr_write_count", 32'(wq_addr_a.size()), 32'd3);
        exp_d[0] = 16'h2211; exp_d[1] = 16'h4433; exp_d[2] = 16'h6655;
        for (int i = 0; i < 3 && i < wq_addr_a.size(); i++) begin
            check_eq("ovr_addr", 32'(wq_addr_a[i]), 32'h100 + 32'(2 * i));
            check_eq("ovr_data", 32'(wq_data_a[i]), 32'(exp_d[i]));
        end
        check_eq("overrun_sticky", 32'(ovr_a), 32'd1);
        check_eq("ovr_done_count", 32'(done_cnt_a), 32'd2);

        // New start clears overrun; reset in WRITING releases the bus at once.
        pulse_start();
        check_eq("overrun_cleared", 32'(ovr_a), 32'd0);
        send_value(16'h8877);
        check_eq("pre_reset_writing", 32'(st_a), 32'd4);
        reset = 1'b1;
        #1;
        check_eq("reset_mid_state", 32'(st_a), 32'd0);
        check_eq("reset_mid_released", 32'(released_a()), 32'd1);
        check_eq("reset_mid_no_done", 32'(done_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_mid_done_count", 32'(done_cnt_a), 32'd2);
        wq_addr_a.delete();
        wq_data_a.delete();
        pulse_start();
        send_value(16'h0001);
        send_value(16'h0002);
        send_value(16'h0003);
        wait_state(3'd0, 40);
        @(negedge clk);
        check_eq("fresh_write_count", 32'(wq_addr_a.size()), 32'd3);
        for (int i = 0; i < 3 && i < wq_addr_a.size(); i++) begin
            check_eq("fresh_addr", 32'(wq_addr_a[i]), 32'h100 + 32'(2 * i));
            check_eq("fresh_data", 32'(wq_data_a[i]), 32'(i + 1));
        end
        check_eq("fresh_done_count", 32'(done_cnt_a), 32'd3);

        // 256-value transfer on the second instance.
        use_b = 1'b1;
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            send_value({8'(i) ^ 8'hA5, 8'(i)});
            check_eq("b_no_early_done", 32'(done_cnt_b), 32'd0);
        end
        wait_state(3'd0, 40);
        @(negedge clk);
        check_eq("b_write_count", 32'(wq_addr_b.size()), 32'd256);
        for (int i = 0; i < 256 && i < wq_addr_b.size(); i++) begin
            check_eq("b_addr", 32'(wq_addr_b[i]), 32'h100 + 32'(2 * i));
            check_eq("b_data", 32'(wq_data_b[i]), 32'({8'(i) ^ 8'hA5, 8'(i)}));
        end
        if (wq_addr_b.size() > 0) begin
            check_eq("b_last_addr", 32'(wq_addr_b[wq_addr_b.size() - 1]), 32'h2FE);
        end else begin
            check_eq("b_last_addr_missing", 32'd0, 32'h2FE);
        end
        check_eq("b_done_count", 32'(done_cnt_b), 32'd1);
        check_eq("b_overrun", 32'(ovr_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
